// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front-end.
//   - PS/2 scan codes of the fixed two-player keyboard map
//   - joystick word bit positions (direction bits, button/start/coin/pause)
//   - ioctl download indices for DIP bytes and game selection
//   - cycle-count helpers for ms and Hz based timing
package arcade_input_pkg;

  // Player 1 keys
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_BTN0  = 8'h14;
  localparam logic [7:0] SC_P1_BTN1  = 8'h11;
  localparam logic [7:0] SC_P1_BTN2  = 8'h29;
  localparam logic [7:0] SC_P1_START = 8'h16;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E;
  localparam logic [7:0] SC_P1_PAUSE = 8'h4D;

  // Player 2 keys
  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_BTN0  = 8'h1C;
  localparam logic [7:0] SC_P2_BTN1  = 8'h1B;
  localparam logic [7:0] SC_P2_BTN2  = 8'h15;
  localparam logic [7:0] SC_P2_START = 8'h1E;
  localparam logic [7:0] SC_P2_COIN  = 8'h36;

  // Direction bits inside a 32-bit joystick word
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;

  localparam logic [15:0] IOCTL_DIP_INDEX  = 16'd254;
  localparam logic [15:0] IOCTL_GAME_INDEX = 16'd1;

  // Which key register (player, bit) a scan code drives
  typedef struct packed {
    logic       hit;
    logic       player;
    logic [4:0] idx;
  } key_slot_t;

  function automatic int btn_bit(input int b);
    return 4 + b;
  endfunction

  function automatic int start_bit(input int nb);
    return 4 + nb;
  endfunction

  function automatic int coin_bit(input int nb);
    return 5 + nb;
  endfunction

  function automatic int pause_bit(input int nb);
    return 6 + nb;
  endfunction

  function automatic int cycles_from_ms(input real mhz, input real ms);
    return int'(mhz * 1000.0 * ms);
  endfunction

  function automatic int half_period_cycles(input real mhz, input real hz);
    return int'(mhz * 1.0e6 / (2.0 * hz));
  endfunction

  function automatic key_slot_t mk_slot(input logic hit, input logic player, input int idx);
    key_slot_t s;
    s.hit    = hit;
    s.player = player;
    s.idx    = 5'(idx);
    return s;
  endfunction

endpackage

// File: rtl/arcade_input_coin_stretch.sv
// Coin pulse stretcher for one player.
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : merged key/joystick coin level
//   coin       : registered coin, high for at least PULSE cycles per accepted edge
module arcade_coin_stretch #(
  parameter int PULSE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic coin
);

  localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PULSE - 1);

  logic          raw_prev;
  logic [CW-1:0] cnt;

  // cnt holds the cycles still owed after the current one, so the edge cycle
  // itself plus RELOAD further cycles gives exactly PULSE high cycles, and a
  // new edge is accepted on the first cycle the output would otherwise fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_prev <= 1'b0;
      cnt      <= '0;
      coin     <= 1'b0;
    end else begin
      raw_prev <= raw;
      coin     <= raw || (cnt != '0);
      if (cnt != '0)
        cnt <= cnt - 1'b1;
      else if (raw && !raw_prev)
        cnt <= RELOAD;
    end
  end

endmodule

// File: rtl/arcade_input.sv
// Arcade input front-end: PS/2 key state merged with HPS joystick words,
// coin stretching, pause toggle, DIP/game-index capture from ioctl.
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (autofire gating of buttons).
//   clk, reset          : system clock, asynchronous active-high reset
//   ps2_key[10:0]       : {strobe toggle, pressed, extended, scan code}
//   joystick            : 32-bit word per player
//   ioctl_*             : download stream (DIP bytes index 254, game index 1)
//   autofire_mask       : per-button autofire enable
//   joy/buttons/start   : registered per-player controls
//   coin                : stretched coin per player
//   pause               : latched pause toggle
//   dip, game_index     : captured from ioctl, untouched by reset
import arcade_input_pkg::*;

module arcade_input #(
  parameter int  NUM_PLAYERS   = 2,
  parameter int  NUM_BUTTONS   = 3,
  parameter int  NUM_DIPS      = 2,
  parameter real CLK_FREQ      = 96.0,
  parameter int  COIN_PULSE_MS = 50,
  parameter int  AUTOFIRE_HZ   = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [10:0]                    ps2_key,
  input  logic [NUM_PLAYERS*32-1:0]      joystick,
  input  logic                           ioctl_wr,
  input  logic [15:0]                    ioctl_index,
  input  logic [26:0]                    ioctl_addr,
  input  logic [7:0]                     ioctl_data,
  input  logic [NUM_BUTTONS-1:0]         autofire_mask,
  output logic [NUM_PLAYERS*4-1:0]       joy,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PLAYERS-1:0]         start,
  output logic [NUM_PLAYERS-1:0]         coin,
  output logic                           pause,
  output logic [NUM_DIPS*8-1:0]          dip,
  output logic [3:0]                     game_index
);

  localparam int COIN_CYCLES = cycles_from_ms(CLK_FREQ, COIN_PULSE_MS);
  localparam int BTN0_BIT    = btn_bit(0);
  localparam int START_BIT   = start_bit(NUM_BUTTONS);
  localparam int COIN_BIT    = coin_bit(NUM_BUTTONS);
  localparam int PAUSE_BIT   = pause_bit(NUM_BUTTONS);

  function automatic key_slot_t decode_key(input logic [7:0] code);
    key_slot_t s;
    s = '0;
    case (code)
      SC_P1_UP:    s = mk_slot(1'b1, 1'b0, JOY_UP);
      SC_P1_DOWN:  s = mk_slot(1'b1, 1'b0, JOY_DOWN);
      SC_P1_LEFT:  s = mk_slot(1'b1, 1'b0, JOY_LEFT);
      SC_P1_RIGHT: s = mk_slot(1'b1, 1'b0, JOY_RIGHT);
      SC_P1_BTN0:  s = mk_slot(1'b1, 1'b0, btn_bit(0));
      SC_P1_BTN1:  s = mk_slot(NUM_BUTTONS > 1, 1'b0, btn_bit(1));
      SC_P1_BTN2:  s = mk_slot(NUM_BUTTONS > 2, 1'b0, btn_bit(2));
      SC_P1_START: s = mk_slot(1'b1, 1'b0, START_BIT);
      SC_P1_COIN:  s = mk_slot(1'b1, 1'b0, COIN_BIT);
      SC_P1_PAUSE: s = mk_slot(1'b1, 1'b0, PAUSE_BIT);
      SC_P2_UP:    s = mk_slot(1'b1, 1'b1, JOY_UP);
      SC_P2_DOWN:  s = mk_slot(1'b1, 1'b1, JOY_DOWN);
      SC_P2_LEFT:  s = mk_slot(1'b1, 1'b1, JOY_LEFT);
      SC_P2_RIGHT: s = mk_slot(1'b1, 1'b1, JOY_RIGHT);
      SC_P2_BTN0:  s = mk_slot(1'b1, 1'b1, btn_bit(0));
      SC_P2_BTN1:  s = mk_slot(NUM_BUTTONS > 1, 1'b1, btn_bit(1));
      SC_P2_BTN2:  s = mk_slot(NUM_BUTTONS > 2, 1'b1, btn_bit(2));
      SC_P2_START: s = mk_slot(1'b1, 1'b1, START_BIT);
      SC_P2_COIN:  s = mk_slot(1'b1, 1'b1, COIN_BIT);
      default:     s = '0;
    endcase
    return s;
  endfunction

  // Key state is kept in joystick-word layout so the merge is a plain OR.
  logic        strobe_prev;
  logic [31:0] keys [2];
  key_slot_t   slot;

  assign slot = decode_key(ps2_key[7:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_prev <= 1'b0;
      keys[0]     <= '0;
      keys[1]     <= '0;
    end else begin
      strobe_prev <= ps2_key[10];
      if ((ps2_key[10] != strobe_prev) && slot.hit)
        keys[slot.player][slot.idx] <= ps2_key[9];
    end
  end

  logic [NUM_PLAYERS*32-1:0] raw;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_raw
    if (p < 2) begin : g_key
      assign raw[32*p +: 32] = joystick[32*p +: 32] | keys[p];
    end else begin : g_joy
      assign raw[32*p +: 32] = joystick[32*p +: 32];
    end
  end

  // Pause from several players at once collapses into one edge.
  logic pause_any;
  always_comb begin
    pause_any = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      pause_any = pause_any | raw[32*p + PAUSE_BIT];
  end

  logic [NUM_BUTTONS-1:0] fire_gate;
  logic                   unused_ok;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AF_HALF = half_period_cycles(CLK_FREQ, AUTOFIRE_HZ);
  localparam int AFW     = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

  logic [AFW-1:0] af_cnt;
  logic           af_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AFW'(AF_HALF - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign fire_gate = ~autofire_mask | {NUM_BUTTONS{af_phase}};
  assign unused_ok = &{1'b0, raw, keys[1], ps2_key[8], ioctl_addr[26:25]};
`else
  assign fire_gate = '1;
  assign unused_ok = &{1'b0, raw, keys[1], ps2_key[8], ioctl_addr[26:25], autofire_mask};
`endif

  logic pause_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy        <= '0;
      buttons    <= '0;
      start      <= '0;
      pause_prev <= 1'b0;
      pause      <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        joy[4*p +: 4] <= {raw[32*p + JOY_UP], raw[32*p + JOY_DOWN],
                          raw[32*p + JOY_RIGHT], raw[32*p + JOY_LEFT]};
        buttons[NUM_BUTTONS*p +: NUM_BUTTONS] <= raw[32*p + BTN0_BIT +: NUM_BUTTONS] & fire_gate;
        start[p] <= raw[32*p + START_BIT];
      end
      pause_prev <= pause_any;
      if (pause_any && !pause_prev)
        pause <= ~pause;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_stretch #(.PULSE(COIN_CYCLES)) u_coin (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[32*p + COIN_BIT]),
      .coin  (coin[p])
    );
  end

  // Download-driven settings persist across reset; power-up value is zero.
  logic [NUM_DIPS*8-1:0] dip_q  = '0;
  logic [3:0]            game_q = '0;
  logic                  dip_sel;

  assign dip_sel = ioctl_wr && (ioctl_index == IOCTL_DIP_INDEX) && (ioctl_addr[24:3] == '0);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIPS; i++)
      if (dip_sel && (ioctl_addr[2:0] == 3'(i)))
        dip_q[8*i +: 8] <= ioctl_data;
    if (ioctl_wr && (ioctl_index == IOCTL_GAME_INDEX))
      game_q <= ioctl_data[3:0];
  end

  assign dip        = dip_q;
  assign game_index = game_q;

endmodule

// File: tb/tb_arcade_input.sv
module tb_arcade_input;

  localparam int ND      = 2;
  localparam int COIN_N  = 1000;
  localparam int AF_HALF = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [63:0] joystick = '0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_index = '0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic [2:0]  autofire_mask = '0;

  logic [7:0]  joy;
  logic [5:0]  buttons;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        pause;
  logic [15:0] dip;
  logic [3:0]  game_index;

  arcade_input #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(3), .NUM_DIPS(ND),
    .CLK_FREQ(1.0), .COIN_PULSE_MS(1), .AUTOFIRE_HZ(1000)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .autofire_mask(autofire_mask),
    .joy(joy), .buttons(buttons), .start(start), .coin(coin), .pause(pause),
    .dip(dip), .game_index(game_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  joy;
    logic [5:0]  btn;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic        pause;
    logic [15:0] dip;
    logic [3:0]  game;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  bit          key_down [256];
  bit          m_strobe;
  int          coin_end [2];
  bit          coin_prev [2];
  bit          m_pause, m_pause_prev;
  logic [15:0] m_dip = '0;
  logic [3:0]  m_game = '0;
  int          cyc = 0;
  int          since_rst = 0;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] codes [0:21] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16,
                               8'h2E, 8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
                               8'h15, 8'h1E, 8'h36, 8'h00, 8'h5A, 8'hF0};

  // Player control word as seen by the game: joystick OR mapped keys.
  function automatic logic [31:0] player_word(input int p);
    logic [31:0] w;
    w = joystick[32*p +: 32];
    if (p == 0) begin
      w[3] |= key_down[8'h75]; w[2] |= key_down[8'h72];
      w[1] |= key_down[8'h6B]; w[0] |= key_down[8'h74];
      w[4] |= key_down[8'h14]; w[5] |= key_down[8'h11]; w[6] |= key_down[8'h29];
      w[7] |= key_down[8'h16]; w[8] |= key_down[8'h2E]; w[9] |= key_down[8'h4D];
    end else begin
      w[3] |= key_down[8'h2D]; w[2] |= key_down[8'h2B];
      w[1] |= key_down[8'h23]; w[0] |= key_down[8'h34];
      w[4] |= key_down[8'h1C]; w[5] |= key_down[8'h1B]; w[6] |= key_down[8'h15];
      w[7] |= key_down[8'h1E]; w[8] |= key_down[8'h36];
    end
    return w;
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
  endtask

  // Evaluate the model for the coming clock edge, queue the expectation,
  // then advance to the next falling edge.
  task automatic step();
    exp_t        e;
    logic [31:0] w [2];
    bit          any, r;
    cyc++;
    e = '0;
    if (ioctl_wr && ioctl_index == 16'd254 && ioctl_addr[24:0] < 25'(ND)) begin
      if (ioctl_addr[0]) m_dip[15:8] = ioctl_data;
      else               m_dip[7:0]  = ioctl_data;
    end
    if (ioctl_wr && ioctl_index == 16'd1) m_game = ioctl_data[3:0];
    e.dip  = m_dip;
    e.game = m_game;
    e.cyc  = cyc;
    if (reset) begin
      foreach (key_down[i]) key_down[i] = 1'b0;
      m_strobe = 1'b0;
      coin_end[0] = 0; coin_end[1] = 0;
      coin_prev[0] = 1'b0; coin_prev[1] = 1'b0;
      m_pause = 1'b0; m_pause_prev = 1'b0;
      since_rst = 0;
    end else begin
      since_rst++;
      for (int p = 0; p < 2; p++) begin
        w[p] = player_word(p);
        e.joy[4*p +: 4] = {w[p][3], w[p][2], w[p][0], w[p][1]};
        for (int b = 0; b < 3; b++) begin
          r = w[p][4+b];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
          if (autofire_mask[b]) r = r & ((((since_rst - 1) / AF_HALF) % 2) == 0);
`endif
          e.btn[3*p + b] = r;
        end
        e.start[p] = w[p][7];
        if (w[p][8] && !coin_prev[p] && cyc >= coin_end[p]) coin_end[p] = cyc + COIN_N;
        e.coin[p] = w[p][8] || (cyc < coin_end[p]);
        coin_prev[p] = w[p][8];
      end
      any = w[0][9] | w[1][9];
      if (any && !m_pause_prev) m_pause = !m_pause;
      m_pause_prev = any;
      e.pause = m_pause;
      if (ps2_key[10] != m_strobe) begin
        key_down[ps2_key[7:0]] = ps2_key[9];
        m_strobe = ps2_key[10];
      end
    end
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic ps2(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'($urandom_range(0, 1)), code};
  endtask

  task automatic ioctl(input logic [15:0] idx, input logic [26:0] addr, input logic [7:0] data);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_data = data;
    step();
    ioctl_wr = 1'b0;
  endtask

  // Monitor: every edge presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("joy",        e.cyc, 32'(joy),        32'(e.joy));
        check("buttons",    e.cyc, 32'(buttons),    32'(e.btn));
        check("start",      e.cyc, 32'(start),      32'(e.start));
        check("coin",       e.cyc, 32'(coin),       32'(e.coin));
        check("pause",      e.cyc, 32'(pause),      32'(e.pause));
        check("dip",        e.cyc, 32'(dip),        32'(e.dip));
        check("game_index", e.cyc, 32'(game_index), 32'(e.game));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    steps(2);

    // Key press / release and idle strobe
    ps2(8'h75, 1'b1); steps(3);
    steps(100);
    ps2(8'h75, 1'b0); steps(3);
    ps2(8'h00, 1'b1); steps(2);
    ps2(8'h1B, 1'b1); steps(3);
    ps2(8'h1B, 1'b0); steps(3);

    // Joystick merge on player 2
    joystick[37] = 1'b1; step();
    joystick[39] = 1'b1; step();
    joystick[40] = 1'b1; step();
    joystick[37] = 1'b0; joystick[39] = 1'b0; joystick[40] = 1'b0;
    steps(1005);

    // Coin stretch: pulse, ignored mid pulse, retrigger at the boundary
    joystick[8] = 1'b1; step(); joystick[8] = 1'b0;
    steps(499);
    joystick[8] = 1'b1; step(); joystick[8] = 1'b0;
    steps(499);
    joystick[8] = 1'b1; step(); joystick[8] = 1'b0;
    steps(1005);

    // Pause toggles
    ps2(8'h4D, 1'b1); steps(10);
    ps2(8'h4D, 1'b0); steps(3);
    joystick[41] = 1'b1; steps(3);
    joystick[41] = 1'b0; steps(2);
    joystick[9] = 1'b1; joystick[41] = 1'b1; steps(3);
    joystick[9] = 1'b0; joystick[41] = 1'b0; steps(2);

    // ioctl capture
    ioctl(16'd254, 27'd1, 8'hA5);
    ioctl(16'd254, 27'd9, 8'h3C);
    ioctl(16'd254, 27'd0, 8'h5A);
    ioctl(16'd1,   27'd0, 8'h03);
    steps(2);

    // Reset mid-stretch with keys held
    joystick[8] = 1'b1; step(); joystick[8] = 1'b0;
    ps2(8'h75, 1'b1); steps(20);
    joystick[4] = 1'b1; step();
    reset = 1'b1; steps(3);
    reset = 1'b0; joystick[4] = 1'b0; steps(3);

    // Autofire mask with buttons 0 and 1 held
    autofire_mask = 3'b001;
    joystick[4] = 1'b1; joystick[5] = 1'b1;
    steps(1200);
    joystick[4] = 1'b0; joystick[5] = 1'b0;
    autofire_mask = 3'b000;
    steps(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        joystick[$urandom_range(0, 9) + 32 * $urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0)
        joystick[$urandom_range(10, 31)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0)
        ps2(codes[$urandom_range(0, 21)], 1'($urandom_range(0, 1)));
      ioctl_wr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       ioctl_index = 16'd254;
        1:       ioctl_index = 16'd1;
        default: ioctl_index = 16'($urandom);
      endcase
      ioctl_addr = ($urandom_range(0, 1) != 0) ? 27'($urandom_range(0, 3)) : 27'($urandom);
      ioctl_data = 8'($urandom);
      autofire_mask = 3'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    ioctl_wr = 1'b0;
    steps(2);

    @(posedge clk);
    #2;
    check("scoreboard_drain", cyc, 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arcade_input.md
Name: arcade_input

Overview:
- Parametrised input front-end for arcade cores.
- Decodes PS/2 key events into held-key state and merges it with HPS joystick words for up to 4 players and up to 8 buttons.
- Stretches coin pulses to a minimum width, turns pause presses into a latched pause toggle, and captures DIP switches and the game index from the ioctl stream.
- Sits between hps_io and the game core in emu; replaces ad-hoc per-core key/DIP logic.

Parameters:
- NUM_PLAYERS, 2, number of players (1..4).
- NUM_BUTTONS, 3, action buttons per player (1..8).
- NUM_DIPS, 2, DIP bytes captured (1..8).
- CLK_FREQ, 96.0, clk frequency in MHz (real).
- COIN_PULSE_MS, 50, minimum coin output width in ms.
- AUTOFIRE_HZ, 15, autofire rate in Hz; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] event strobe (toggles per event), [9] pressed, [7:0] scan code.
- joystick  in  NUM_PLAYERS*32  player p occupies bits [32p+31:32p].
- ioctl_wr  in  1  download byte strobe.
- ioctl_index  in  16  download index.
- ioctl_addr  in  27  download byte address.
- ioctl_data  in  8  download byte.
- autofire_mask  in  NUM_BUTTONS  per-button autofire enable.
- joy  out  NUM_PLAYERS*4  per player {up,down,right,left}.
- buttons  out  NUM_PLAYERS*NUM_BUTTONS  per player, button 0 in the LSB.
- start  out  NUM_PLAYERS  start, per player.
- coin  out  NUM_PLAYERS  stretched coin, per player.
- pause  out  1  latched pause.
- dip  out  NUM_DIPS*8  byte i at [8i+7:8i].
- game_index  out  4  selected game.

Behaviour:
- Reset scope:
  - Asynchronous reset clears key registers, ps2 strobe history, output registers, coin counters and pause (all outputs 0 except dip/game_index).
  - dip and game_index are not affected by reset. They power up 0 and are only changed by ioctl.
- Joystick bit layout:
  - 0 right, 1 left, 2 down, 3 up.
  - 4+b is button b.
  - 4+NUM_BUTTONS is start, 5+NUM_BUTTONS is coin, 6+NUM_BUTTONS is pause.
- PS/2 decoding:
  - On any clk edge where ps2_key[10] differs from its stored previous value, the key register matching code[7:0] loads ps2_key[9].
  - Bit 8 (extended) is ignored. Unknown codes are ignored.
- Key map (hex), fixed:
  - P1: up 75, down 72, left 6B, right 74; buttons 14, 11, 29; start 16, coin 2E, pause 4D.
  - P2: up 2D, down 2B, left 23, right 34; buttons 1C, 1B, 15; start 1E, coin 36.
  - Players 3..4 and buttons 3..7 are joystick-only.
- Merge: raw signal = key OR joystick bit. Outputs are registered.
  - Latency: joystick bit to output 1 cycle; ps2 strobe toggle to output 2 cycles.
- Coin stretch (per player):
  - Counter N = round(CLK_FREQ*1000*COIN_PULSE_MS).
  - A rising edge of raw coin while the counter is 0 loads N.
  - coin = (counter != 0) OR raw coin. The counter decrements to 0.
  - Edges while the counter is nonzero are ignored (no retrigger).
- Pause:
  - A rising edge of the OR of all raw pause bits toggles pause.
  - Simultaneous presses from several players count as one edge.
- ioctl capture:
  - ioctl_wr && ioctl_index==254 && ioctl_addr[24:3]==0 && ioctl_addr[2:0]<NUM_DIPS: dip[ioctl_addr[2:0]] <= data.
  - ioctl_wr && ioctl_index==1: game_index <= data[3:0]. The last write wins.
- Reset mid-stretch aborts the pulse (coin drops immediately) and clears pause.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- When defined:
  - A free-running divider toggles a fire phase every round(CLK_FREQ*1e6/(2*AUTOFIRE_HZ)) cycles. The phase resets to 1.
  - A button with autofire_mask[b]=1 outputs raw AND phase.
- When undefined: autofire_mask is ignored, buttons pass through, and no divider logic is built.

Decomposition:
- Package arcade_input_pkg:
  - scan-code constants;
  - joystick bit-index functions (btn_bit(b), start_bit, coin_bit, pause_bit of NUM_BUTTONS);
  - IOCTL_DIP_INDEX=254 and IOCTL_GAME_INDEX=1;
  - a cycles-from-ms helper function.
- Sub-module arcade_coin_stretch: one instance per player (edge detect + counter).

Test Plan (bench runs CLK_FREQ=1.0, COIN_PULSE_MS=1, so N=1000):
- P1 key press: toggle ps2_key[10] with code 75, pressed=1 → joy[3]=1 two cycles later. Toggle again with pressed=0 → 0. Holding the strobe unchanged for 100 cycles causes no further change.
- Joystick merge: joystick[32+4+1]=1 (P2 button 1) → buttons[NUM_BUTTONS+1]=1 after 1 cycle. Bit 7 → start[1]. Bit 8 → coin[1].
- Coin stretch: 1-cycle raw coin → coin high exactly 1000 cycles. Second pulse at cycle 500 → no extension. Pulse at cycle 1001 → new 1000-cycle pulse.
- Pause: P1 pause held 10 cycles → pause=1. Release and press joystick pause on P2 → pause=0. Simultaneous presses from both → single toggle.
- ioctl:
  - index 254, addr 1, data A5 → dip[15:8]=A5.
  - addr 9 → ignored.
  - index 1, data 03 → game_index=3.
  - Assert reset → dip and game_index unchanged, all other outputs 0.
- ARCADE_INPUT_AUTOFIRE_EN with AUTOFIRE_HZ=1000, mask=001, button 0 held → output toggles every 500 cycles. Button 1 steady.
